// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC bank sequencer.
package mac_ctrl_pkg;

    localparam int NUM_MAC     = 12;
    localparam int DIN_W       = 128;
    localparam int WGT_W       = 73;
    localparam int OUT_W       = 20;
    localparam int MAC_LAT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Per-beat flags carried down the delay pipes.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } vld_flags_t;

endpackage

// File: rtl/mac_ctrl_vld_pipe.sv
// Fixed-depth shift register for beat flags (vld, first, last), synchronous clear.
module mac_ctrl_vld_pipe
    import mac_ctrl_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       clr_i,
    input  vld_flags_t flags_i,
    output vld_flags_t flags_o
);

    vld_flags_t pipe_q [DEPTH];

    // Shift flags one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= flags_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign flags_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mac_bank_ctrl.sv
// Sequencer for the 12-lane MAC bank: latches a job on start, issues one
// buffer read per beat, and delays beat flags to line up with bank outputs.
// Optional macro MAC_CTRL_PERF_EN adds busy/stall cycle counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i; cfg latched on acceptance
// ST_ISSUE | one read per unstalled cycle, beat/tile counters advance
// ST_DRAIN | wait MAC_LAT+1 cycles for the last beat to leave the bank
// ST_DONE  | one-cycle done_o pulse, then back to idle
module mac_bank_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int MAC_LAT = MAC_LAT_DEF,
    parameter int CNT_W   = 16,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  cfg_beats_i,
    input  logic [CNT_W-1:0]  cfg_tiles_i,
    input  logic [ADDR_W-1:0] cfg_din_base_i,
    input  logic [ADDR_W-1:0] cfg_wgt_base_i,
    input  logic              stall_i,
    output logic              buf_rd_en_o,
    output logic [ADDR_W-1:0] din_addr_o,
    output logic [ADDR_W-1:0] wgt_addr_o,
    output logic              mac_vld_o,
    output logic              out_vld_o,
    output logic              out_first_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
`ifdef MAC_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_busy_cyc_o,
    output logic [31:0]       perf_stall_cyc_o
`endif
);

    // Wide enough to hold MAC_LAT even when MAC_LAT is 0.
    localparam int DRAIN_W = $clog2(MAC_LAT + 2);

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    n_q,        n_d;
    logic [CNT_W-1:0]    t_q,        t_d;
    logic [ADDR_W-1:0]   din_base_q, din_base_d;
    logic [ADDR_W-1:0]   wgt_base_q, wgt_base_d;
    logic [CNT_W-1:0]    beat_q,     beat_d;
    logic [CNT_W-1:0]    tile_q,     tile_d;
    logic [ADDR_W-1:0]   wgt_off_q,  wgt_off_d;
    logic [DRAIN_W-1:0]  drain_q,    drain_d;

    logic       issue;
    logic       last_beat;
    logic       last_tile;
    logic       start_acc;
    vld_flags_t issue_flags;
    vld_flags_t mac_flags;
    vld_flags_t out_flags;
    logic       unused_mac_flags;

    assign issue     = (state_q == ST_ISSUE) && !stall_i;
    assign last_beat = (beat_q == n_q - CNT_W'(1));
    assign last_tile = (tile_q == t_q - CNT_W'(1));
    assign start_acc = (state_q == ST_IDLE) && start_i;

    // State and job registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            t_q        <= '0;
            din_base_q <= '0;
            wgt_base_q <= '0;
            beat_q     <= '0;
            tile_q     <= '0;
            wgt_off_q  <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            t_q        <= t_d;
            din_base_q <= din_base_d;
            wgt_base_q <= wgt_base_d;
            beat_q     <= beat_d;
            tile_q     <= tile_d;
            wgt_off_q  <= wgt_off_d;
            drain_q    <= drain_d;
        end
    end

    // Next-state logic: job latch, beat/tile walk, drain down-counter.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        t_d        = t_q;
        din_base_d = din_base_q;
        wgt_base_d = wgt_base_q;
        beat_d     = beat_q;
        tile_d     = tile_q;
        wgt_off_d  = wgt_off_q;
        drain_d    = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d        = cfg_beats_i;
                    t_d        = cfg_tiles_i;
                    din_base_d = cfg_din_base_i;
                    wgt_base_d = cfg_wgt_base_i;
                    beat_d     = '0;
                    tile_d     = '0;
                    wgt_off_d  = '0;
                    if ((cfg_beats_i == '0) || (cfg_tiles_i == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!stall_i) begin
                    // Weight offset runs continuously across tiles (tile*N + beat).
                    wgt_off_d = wgt_off_q + ADDR_W'(1);
                    if (last_beat) begin
                        beat_d = '0;
                        tile_d = tile_q + CNT_W'(1);
                        if (last_tile) begin
                            state_d = ST_DRAIN;
                            drain_d = DRAIN_W'(MAC_LAT);
                        end
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Input addresses restart each tile so the same activations meet every tile's weights.
    assign buf_rd_en_o = issue;
    assign din_addr_o  = din_base_q + ADDR_W'(beat_q);
    assign wgt_addr_o  = wgt_base_q + wgt_off_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

    assign issue_flags.vld   = issue;
    assign issue_flags.first = issue && (beat_q == '0);
    assign issue_flags.last  = issue && last_beat;

    mac_ctrl_vld_pipe #(
        .DEPTH (1)
    ) u_mac_pipe (
        .clk     (clk),
        .clr_i   (rst),
        .flags_i (issue_flags),
        .flags_o (mac_flags)
    );

    mac_ctrl_vld_pipe #(
        .DEPTH (1 + MAC_LAT)
    ) u_out_pipe (
        .clk     (clk),
        .clr_i   (rst),
        .flags_i (issue_flags),
        .flags_o (out_flags)
    );

    // The bank only needs the strobe; first/last of the short pipe are not consumed.
    assign mac_vld_o        = mac_flags.vld;
    assign unused_mac_flags = mac_flags.first ^ mac_flags.last;

    assign out_vld_o   = out_flags.vld;
    assign out_first_o = out_flags.first;
    assign out_last_o  = out_flags.last;

`ifdef MAC_CTRL_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    // Saturating busy/stall counters, cleared when a job is accepted.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((state_q != ST_IDLE) && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((state_q == ST_ISSUE) && stall_i && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_cyc_o  = perf_busy_q;
    assign perf_stall_cyc_o = perf_stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_mac_bank_ctrl.sv
// Self-checking bench for mac_bank_ctrl (MAC_LAT = 4).
module tb_mac_bank_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 16;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [CW-1:0] cfg_beats_i;
    logic [CW-1:0] cfg_tiles_i;
    logic [AW-1:0] cfg_din_base_i;
    logic [AW-1:0] cfg_wgt_base_i;
    logic          stall_i;
    logic          buf_rd_en_o;
    logic [AW-1:0] din_addr_o;
    logic [AW-1:0] wgt_addr_o;
    logic          mac_vld_o;
    logic          out_vld_o;
    logic          out_first_o;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;
`ifdef MAC_CTRL_PERF_EN
    logic [31:0]   perf_busy_cyc_o;
    logic [31:0]   perf_stall_cyc_o;
`endif

    always #5 clk = ~clk;

    mac_bank_ctrl #(
        .MAC_LAT (LAT),
        .CNT_W   (CW),
        .ADDR_W  (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .cfg_beats_i    (cfg_beats_i),
        .cfg_tiles_i    (cfg_tiles_i),
        .cfg_din_base_i (cfg_din_base_i),
        .cfg_wgt_base_i (cfg_wgt_base_i),
        .stall_i        (stall_i),
        .buf_rd_en_o    (buf_rd_en_o),
        .din_addr_o     (din_addr_o),
        .wgt_addr_o     (wgt_addr_o),
        .mac_vld_o      (mac_vld_o),
        .out_vld_o      (out_vld_o),
        .out_first_o    (out_first_o),
        .out_last_o     (out_last_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
`ifdef MAC_CTRL_PERF_EN
        ,
        .perf_busy_cyc_o  (perf_busy_cyc_o),
        .perf_stall_cyc_o (perf_stall_cyc_o)
`endif
    );

    typedef struct {
        int            n;
        int            t;
        logic [AW-1:0] din;
        logic [AW-1:0] wgt;
        int            st_lo;
        int            st_hi;
        int            exp_done;
    } vec_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] din;
        logic [AW-1:0] wgt;
    } rd_t;

    typedef struct {
        int   cyc;
        logic first;
        logic last;
    } ov_t;

    rd_t  rd_q[$];
    ov_t  ov_q[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int cyc, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // Runs one job with start at relative cycle 0; poke adds ignored starts and a cfg change.
    task automatic run_job(input vec_t v, input bit poke);
        bit  exp_mac[128];
        int  c;
        int  last_rd;
        int  stall_cnt;
        rd_t r;
        ov_t o;

        rd_q.delete();
        ov_q.delete();
        for (int i = 0; i < 128; i++) exp_mac[i] = 1'b0;
        c         = 1;
        last_rd   = 0;
        stall_cnt = 0;
        for (int tl = 0; tl < v.t; tl++) begin
            for (int b = 0; b < v.n; b++) begin
                while (c >= v.st_lo && c <= v.st_hi) c++;
                r.cyc = c;
                r.din = AW'(int'(v.din) + b);
                r.wgt = AW'(int'(v.wgt) + tl * v.n + b);
                rd_q.push_back(r);
                o.cyc   = c + 1 + LAT;
                o.first = (b == 0);
                o.last  = (b == v.n - 1);
                ov_q.push_back(o);
                exp_mac[c + 1] = 1'b1;
                last_rd = c;
                c++;
            end
        end
        for (int s = v.st_lo; s <= v.st_hi; s++) begin
            if (s >= 1 && s < last_rd) stall_cnt++;
        end

        for (int cyc = 0; cyc <= v.exp_done + 3; cyc++) begin
            start_i = (cyc == 0) || (poke && (cyc == 2 || cyc == v.exp_done));
            if (cyc == 0) begin
                cfg_beats_i    = CW'(v.n);
                cfg_tiles_i    = CW'(v.t);
                cfg_din_base_i = v.din;
                cfg_wgt_base_i = v.wgt;
            end else if (cyc == 1) begin
                cfg_beats_i    = 16'h0007;
                cfg_din_base_i = 12'h555;
            end
            if (poke && cyc == 2) begin
                cfg_beats_i    = 16'h0001;
                cfg_tiles_i    = 16'h0009;
                cfg_din_base_i = 12'h3AA;
                cfg_wgt_base_i = 12'h0C3;
            end
            stall_i = (cyc >= v.st_lo) && (cyc <= v.st_hi);
            #1;
            if (buf_rd_en_o) begin
                if (rd_q.size() == 0) begin
                    chk1("rd_unexpected", cyc, 1'b1, 1'b0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_cycle", cyc, 32'(cyc), 32'(r.cyc));
                    chk("din_addr", cyc, 32'(din_addr_o), 32'(r.din));
                    chk("wgt_addr", cyc, 32'(wgt_addr_o), 32'(r.wgt));
                end
            end
            if (out_vld_o) begin
                if (ov_q.size() == 0) begin
                    chk1("out_vld_unexpected", cyc, 1'b1, 1'b0);
                end else begin
                    o = ov_q.pop_front();
                    chk("out_cycle", cyc, 32'(cyc), 32'(o.cyc));
                    chk1("out_first", cyc, out_first_o, o.first);
                    chk1("out_last", cyc, out_last_o, o.last);
                end
            end
            chk1("mac_vld", cyc, mac_vld_o, exp_mac[cyc]);
            chk1("busy", cyc, busy_o, (cyc >= 1) && (cyc <= v.exp_done));
            chk1("done", cyc, done_o, cyc == v.exp_done);
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        chk("reads_missing", v.exp_done, 32'(rd_q.size()), 32'd0);
        chk("outs_missing", v.exp_done, 32'(ov_q.size()), 32'd0);
`ifdef MAC_CTRL_PERF_EN
        chk("perf_busy", v.exp_done, perf_busy_cyc_o, 32'(v.exp_done));
        chk("perf_stall", v.exp_done, perf_stall_cyc_o, 32'(stall_cnt));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            n  t  din     wgt     st_lo st_hi done
        vecs[0] = '{3, 2, 12'h010, 12'h100, 0, -1, 12};
        vecs[1] = '{4, 1, 12'h020, 12'h200, 2,  3, 12};
        vecs[2] = '{0, 5, 12'h040, 12'h400, 0, -1,  1};
        vecs[3] = '{1, 1, 12'h7FF, 12'h7FF, 0, -1,  7};
        vecs[4] = '{5, 3, 12'hFFE, 12'hFFC, 7,  9, 24};
        vecs[5] = '{2, 0, 12'h123, 12'h456, 0, -1,  1};
        vecs[6] = '{4, 2, 12'h080, 12'h800, 1,  1, 15};

        rst            = 1'b1;
        start_i        = 1'b0;
        stall_i        = 1'b0;
        cfg_beats_i    = '0;
        cfg_tiles_i    = '0;
        cfg_din_base_i = '0;
        cfg_wgt_base_i = '0;
        repeat (2) @(posedge clk);
        #2;
        chk1("rst_rd_en", 0, buf_rd_en_o, 1'b0);
        chk("rst_din", 0, 32'(din_addr_o), 32'd0);
        chk("rst_wgt", 0, 32'(wgt_addr_o), 32'd0);
        chk1("rst_mac_vld", 0, mac_vld_o, 1'b0);
        chk1("rst_out_vld", 0, out_vld_o, 1'b0);
        chk1("rst_busy", 0, busy_o, 1'b0);
        chk1("rst_done", 0, done_o, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i], 1'b0);
        end

        // Starts during a job and in DONE, plus a cfg change mid-job, are ignored.
        run_job(vecs[0], 1'b1);

        // Reset mid-job aborts at once; a later start runs a normal job.
        for (int cyc = 0; cyc < 10; cyc++) begin
            start_i = (cyc == 0);
            if (cyc == 0) begin
                cfg_beats_i    = 16'd3;
                cfg_tiles_i    = 16'd2;
                cfg_din_base_i = 12'h010;
                cfg_wgt_base_i = 12'h100;
            end
            rst = (cyc == 3);
            #1;
            if (cyc == 1 || cyc == 2) begin
                chk1("abort_pre_rd", cyc, buf_rd_en_o, 1'b1);
            end
            if (cyc >= 4) begin
                chk1("abort_rd_en", cyc, buf_rd_en_o, 1'b0);
                chk("abort_din", cyc, 32'(din_addr_o), 32'd0);
                chk("abort_wgt", cyc, 32'(wgt_addr_o), 32'd0);
                chk1("abort_mac_vld", cyc, mac_vld_o, 1'b0);
                chk1("abort_out_vld", cyc, out_vld_o, 1'b0);
                chk1("abort_busy", cyc, busy_o, 1'b0);
                chk1("abort_done", cyc, done_o, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        start_i = 1'b0;
        run_job(vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
